// File: rtl/branch_predictor_bht_if.sv
// Fetch/resolve interface of the branch history table: lookup, training,
// statistics and global-history observation, bundled for the core side and the predictor side.
interface branch_predictor_bht_if #(
    parameter int ADDR_W = 16,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 0,
    parameter int STAT_W = 16
);
    localparam int GHR_W = (HIST_W > 0) ? HIST_W : 1;

    logic [ADDR_W-1:0] lookup_pc;
    logic              predict_taken;
    logic [CTR_W-1:0]  predict_ctr;

    logic              update_valid;
    logic [ADDR_W-1:0] update_pc;
    logic              update_taken;
    logic              update_predicted;

    logic              stats_clear;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] mispredict_count;
    logic [GHR_W-1:0]  ghr;

    modport master (
        output lookup_pc,
        output update_valid,
        output update_pc,
        output update_taken,
        output update_predicted,
        output stats_clear,
        input  predict_taken,
        input  predict_ctr,
        input  branch_count,
        input  mispredict_count,
        input  ghr
    );

    modport slave (
        input  lookup_pc,
        input  update_valid,
        input  update_pc,
        input  update_taken,
        input  update_predicted,
        input  stats_clear,
        output predict_taken,
        output predict_ctr,
        output branch_count,
        output mispredict_count,
        output ghr
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table: zero-latency taken/not-taken prediction from saturating
// counters, trained on branch resolution, with optional gshare indexing and debug statistics.
module branch_predictor_bht #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int PC_LSB = 1,
    parameter int HIST_W = 0,
    parameter int STAT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    branch_predictor_bht_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int GHR_W   = (HIST_W > 0) ? HIST_W : 1;

    localparam logic [CTR_W-1:0]  WNT      = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    if (CTR_W < 2 || CTR_W > 4) begin : g_bad_ctr_w
        $fatal(1, "branch_predictor_bht: CTR_W must lie in 2..4");
    end
    if (HIST_W < 0 || HIST_W > IDX_W) begin : g_bad_hist_w
        $fatal(1, "branch_predictor_bht: HIST_W must lie in 0..IDX_W");
    end
    if (PC_LSB + IDX_W > ADDR_W) begin : g_bad_pc_range
        $fatal(1, "branch_predictor_bht: PC_LSB+IDX_W exceeds ADDR_W");
    end

    logic [ENTRIES-1:0][CTR_W-1:0] table_val;
    logic [GHR_W-1:0]              ghr_reg;
    logic [IDX_W-1:0]              hist_mask;
    logic [IDX_W-1:0]              lookup_idx;
    logic [IDX_W-1:0]              upd_idx;
    logic [CTR_W-1:0]              upd_ctr;
    logic [CTR_W-1:0]              ctr_next;
    logic [STAT_W-1:0]             branch_count_reg;
    logic [STAT_W-1:0]             mispredict_count_reg;
    logic [STAT_W-1:0]             branch_count_next;
    logic [STAT_W-1:0]             mispredict_count_next;

    function automatic logic [IDX_W-1:0] make_idx(
        input logic [ADDR_W-1:0] pc,
        input logic [IDX_W-1:0]  hist
    );
        return pc[PC_LSB +: IDX_W] ^ hist;
    endfunction

    // Lookup and update both index with the history as it stands before this edge.
    assign lookup_idx = make_idx(bus.lookup_pc, hist_mask);
    assign upd_idx    = make_idx(bus.update_pc, hist_mask);

    assign bus.predict_ctr   = table_val[lookup_idx];
    assign bus.predict_taken = table_val[lookup_idx][CTR_W-1];

    always_comb begin
        upd_ctr  = table_val[upd_idx];
        ctr_next = upd_ctr;
        if (bus.update_taken) begin
            if (upd_ctr != CTR_MAX) begin
                ctr_next = upd_ctr + CTR_W'(1);
            end
        end else if (upd_ctr != '0) begin
            ctr_next = upd_ctr - CTR_W'(1);
        end
    end

    // Counters live in flops rather than RAM: every entry needs an immediate
    // asynchronous reset to WNT and the read path must be combinational.
    genvar gi;
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic [CTR_W-1:0] ctr_reg;
        logic             wr_en;

        assign wr_en = bus.update_valid && (upd_idx == IDX_W'(gi));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                ctr_reg <= WNT;
            end else if (wr_en) begin
                ctr_reg <= ctr_next;
            end
        end

        assign table_val[gi] = ctr_reg;
    end

    if (HIST_W > 0) begin : g_gshare
        logic [GHR_W:0] ghr_shift;

        assign ghr_shift = {ghr_reg, bus.update_taken};
        assign hist_mask = IDX_W'(ghr_reg);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                ghr_reg <= '0;
            end else if (bus.update_valid) begin
                ghr_reg <= ghr_shift[GHR_W-1:0];
            end
        end
    end else begin : g_bimodal
        assign hist_mask = '0;
        assign ghr_reg   = '0;
    end

    assign bus.ghr = ghr_reg;

    always_comb begin
        branch_count_next     = branch_count_reg;
        mispredict_count_next = mispredict_count_reg;
        if (bus.stats_clear) begin
            branch_count_next     = '0;
            mispredict_count_next = '0;
        end else if (bus.update_valid) begin
            if (branch_count_reg != STAT_MAX) begin
                branch_count_next = branch_count_reg + STAT_W'(1);
            end
            if ((bus.update_taken != bus.update_predicted) && (mispredict_count_reg != STAT_MAX)) begin
                mispredict_count_next = mispredict_count_reg + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            branch_count_reg     <= branch_count_next;
            mispredict_count_reg <= mispredict_count_next;
        end
    end

    assign bus.branch_count     = branch_count_reg;
    assign bus.mispredict_count = mispredict_count_reg;

    // Only the index field of each PC feeds the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc, bus.update_pc};

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised branch history table (BHT) for the pipelined PMIPS core.
- Gives a same-cycle taken/not-taken prediction for the fetch PC, and trains saturating counters when a branch resolves.
- Optional gshare mode XORs a global history register into the index.
- Keeps saturating branch and mispredict counters for debug and bench monitoring.

Parameters:
- ADDR_W, 16, PC width.
- IDX_W, 4, table index width; table has 2^IDX_W entries.
- CTR_W, 2, saturating counter width; range 2..4.
- PC_LSB, 1, lowest PC bit used for indexing (16-bit instructions, byte addressed).
- HIST_W, 0, global history length; 0 selects bimodal mode, 1..IDX_W selects gshare.
- STAT_W, 16, width of statistics counters.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_pc  in  ADDR_W  PC of the instruction in IF.
- predict_taken  out  1  combinational prediction for lookup_pc.
- predict_ctr  out  CTR_W  counter value behind the prediction (debug).
- update_valid  in  1  a conditional branch resolves this cycle.
- update_pc  in  ADDR_W  PC of the resolving branch.
- update_taken  in  1  actual outcome.
- update_predicted  in  1  prediction that was used for this branch.
- stats_clear  in  1  synchronous clear of the statistics counters.
- branch_count  out  STAT_W  number of resolved branches, saturating.
- mispredict_count  out  STAT_W  number of mispredicts, saturating.
- ghr  out  max(HIST_W,1)  global history register; reads 0 when HIST_W=0.

Behaviour:
- Reset value of counters: WNT = 2^(CTR_W-1)-1 (01 for CTR_W=2).
- Reset values of other state and outputs:
  - All table entries are set to WNT.
  - ghr=0, branch_count=0, mispredict_count=0.
  - After reset, predict_taken=0 and predict_ctr=WNT for any PC.
- Asynchronous reset:
  - Asserting reset at any time, including mid-update, clears state immediately.
  - No update is applied on the edge at which reset deasserts if reset is still low at that edge.
- Index:
  - base(pc) = pc[PC_LSB+IDX_W-1 : PC_LSB].
  - HIST_W=0: idx = base(pc).
  - HIST_W>0: idx = base(pc) XOR {zeros, ghr[HIST_W-1:0]}.
  - Lookup uses the current ghr; update uses the current ghr before the shift.
- Prediction:
  - Purely combinational, zero latency.
  - predict_ctr = table[idx(lookup_pc)].
  - predict_taken = MSB of predict_ctr.
- Update, on the rising edge with update_valid=1:
  - update_taken=1: the counter increments and saturates at 2^CTR_W-1.
  - update_taken=0: the counter decrements and saturates at 0.
  - ghr <= {ghr[HIST_W-2:0], update_taken} (single-bit shift when HIST_W=1; no register when HIST_W=0).
  - branch_count increments unless it is all-ones.
  - mispredict_count increments when update_taken != update_predicted, unless it is all-ones.
- update_valid=0: no state change; the update_* inputs are ignored.
- Simultaneous lookup and update to the same index:
  - The lookup returns the pre-update value; there is no bypass.
  - The new value is visible the cycle after the edge.
- Aliasing: distinct PCs mapping to the same idx share an entry; this is intended and not detected.
- stats_clear=1 on an edge:
  - Both stat counters become 0.
  - It takes priority over a same-edge increment.
  - The table and ghr are unaffected.
- Arithmetic: all counter updates are CTR_W/STAT_W wide with explicit saturation; wrap-around never occurs.
- Illegal parameters must halt elaboration via a generate-time check:
  - CTR_W<2 or CTR_W>4.
  - HIST_W>IDX_W.
  - PC_LSB+IDX_W>ADDR_W.

Test Plan:
- Reset, bimodal defaults, lookup_pc=0x0010 -> predict_taken=0, predict_ctr=01; branch_count=0.
- Three updates to pc=0x0010 with taken=1, predicted=0:
  - predict_ctr steps 10, 11, 11 (saturates); predict_taken=1 after the first edge.
  - branch_count=3, mispredict_count=3.
- Four not-taken updates to pc=0x0010 from 11:
  - Counter goes 10, 01, 00, 00.
  - pc=0x0030 aliases (IDX_W=4, base=8 for both) and shows the same value.
- Same-cycle lookup and update at pc=0x0004, taken, from 01 -> predict_ctr=01 during that cycle, 10 on the next.
- HIST_W=2, after taken and not-taken updates (ghr=10):
  - Lookup pc=0x0002 (base 1) reads entry 3.
  - The next update at pc=0x0002 trains entry 3 and sets ghr=01.
- STAT_W=4:
  - 20 mispredicting updates -> both counters hold at 15.
  - stats_clear on the same edge as an update -> both read 0.
  - Reset pulsed low mid-sequence -> the table reads 01 immediately, with no clock edge.
